// File: rtl/cmdin_queue_dispatcher.sv
// -----------------------------------------------------------------------------
// cmdin_queue_dispatcher
//
// Walks the CmdInQueue BRAM one subqueue at a time in round-robin order. When
// the header at a subqueue's read pointer has its valid bit (63) set, the
// command (header plus N = header[15:8] argument words) is streamed out on
// cmdin_out with tdest = accelerator id. Afterwards only the header's top byte
// is written to zero and the read pointer moves past the command. A header
// whose N cannot fit in a subqueue is dropped (header cleared, pointer + 1) and
// raises the sticky dispatch_err.
//
// Ports
//   aclk, peripheral_aresetn   clock, asynchronous active-low reset
//   cmdin_queue_en/we/addr/din BRAM port (byte address, 1-cycle read latency)
//   cmdin_queue_dout           BRAM read data
//   cmdin_out_*                AXI-Stream master (tvalid/tready/tdest/tdata/tlast)
//   dispatch_err               sticky malformed-header flag
//   dispatch_count             (CMDIN_DISPATCH_STATS_EN only) well-formed
//                              commands dispatched, wraps at 2^32
//
// Optional feature macro: CMDIN_DISPATCH_STATS_EN
// -----------------------------------------------------------------------------
module cmdin_queue_dispatcher #(
  parameter int unsigned MAX_ACCS           = 16,
  parameter int unsigned CMDIN_SUBQUEUE_LEN = 64
) (
  input  logic                        aclk,
  input  logic                        peripheral_aresetn,
  output logic                        cmdin_queue_en,
  output logic [7:0]                  cmdin_queue_we,
  output logic [31:0]                 cmdin_queue_addr,
  output logic [63:0]                 cmdin_queue_din,
  input  logic [63:0]                 cmdin_queue_dout,
  output logic                        cmdin_out_tvalid,
  input  logic                        cmdin_out_tready,
  output logic [$clog2(MAX_ACCS)-1:0] cmdin_out_tdest,
  output logic [63:0]                 cmdin_out_tdata,
  output logic                        cmdin_out_tlast,
`ifdef CMDIN_DISPATCH_STATS_EN
  output logic [31:0]                 dispatch_count,
`endif
  output logic                        dispatch_err
);

  localparam int unsigned ACC_W  = $clog2(MAX_ACCS);
  localparam int unsigned SLOT_W = $clog2(CMDIN_SUBQUEUE_LEN);

  typedef enum logic [2:0] {
    S_SCAN, S_HWAIT, S_SEND, S_RD, S_RWAIT, S_CLEAR
  } state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [SLOT_W-1:0] rd_ptr [MAX_ACCS];
  logic [SLOT_W-1:0] cur_ptr;
  logic [SLOT_W-1:0] slot;
  logic [7:0]        n_args;
  logic [7:0]        k;
  logic              bad_hdr;
  logic [7:0]        hdr_n;
  logic              hdr_valid;
  logic              hdr_malformed;

  assign cur_ptr         = rd_ptr[acc];
  assign hdr_n           = cmdin_queue_dout[15:8];
  assign hdr_valid       = cmdin_queue_dout[63];
  assign hdr_malformed   = 32'(hdr_n) >= CMDIN_SUBQUEUE_LEN;
  // acc only changes on an empty check or in CLEAR, so tdest is stable
  // for the whole command.
  assign cmdin_out_tdest = acc;

  // State register
  always_ff @(posedge aclk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) state <= S_SCAN;
    else                     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_SCAN:  state_nxt = S_HWAIT;
      S_HWAIT: begin
        if (!hdr_valid)         state_nxt = S_SCAN;
        else if (hdr_malformed) state_nxt = S_CLEAR;
        else                    state_nxt = S_SEND;
      end
      S_SEND:  if (cmdin_out_tready) state_nxt = cmdin_out_tlast ? S_CLEAR : S_RD;
      S_RD:    state_nxt = S_RWAIT;
      S_RWAIT: state_nxt = S_SEND;
      S_CLEAR: state_nxt = S_SCAN;
      default: state_nxt = S_SCAN;
    endcase
  end

  // BRAM port outputs. Gating with the reset keeps the port quiet while
  // reset is held even though the reset state is SCAN.
  always_comb begin
    cmdin_queue_en   = 1'b0;
    cmdin_queue_we   = 8'h00;
    cmdin_queue_addr = 32'h0;
    cmdin_queue_din  = 64'h0;
    slot             = cur_ptr;
    // Argument slots wrap inside the subqueue through SLOT_W-bit arithmetic.
    if (state == S_RD) slot = cur_ptr + SLOT_W'(k);
    if (peripheral_aresetn &&
        (state == S_SCAN || state == S_RD || state == S_CLEAR)) begin
      cmdin_queue_en   = 1'b1;
      cmdin_queue_addr = 32'({acc, slot}) << 3;
      // Only the byte holding the valid bit is rewritten.
      if (state == S_CLEAR) cmdin_queue_we = 8'h80;
    end
  end

  // Stream, pointer and status registers
  always_ff @(posedge aclk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      acc              <= '0;
      n_args           <= '0;
      k                <= '0;
      bad_hdr          <= 1'b0;
      cmdin_out_tvalid <= 1'b0;
      cmdin_out_tdata  <= '0;
      cmdin_out_tlast  <= 1'b0;
      dispatch_err     <= 1'b0;
      for (int unsigned i = 0; i < MAX_ACCS; i++) rd_ptr[i] <= '0;
`ifdef CMDIN_DISPATCH_STATS_EN
      dispatch_count   <= '0;
`endif
    end else begin
      case (state)
        S_HWAIT: begin
          if (!hdr_valid) begin
            acc <= acc + ACC_W'(1);
          end else if (hdr_malformed) begin
            // Treat as a one-word command so the pointer steps past it.
            dispatch_err <= 1'b1;
            bad_hdr      <= 1'b1;
            n_args       <= '0;
          end else begin
            bad_hdr          <= 1'b0;
            n_args           <= hdr_n;
            k                <= '0;
            cmdin_out_tdata  <= cmdin_queue_dout;
            cmdin_out_tlast  <= (hdr_n == 8'd0);
            cmdin_out_tvalid <= 1'b1;
          end
        end
        S_SEND: begin
          if (cmdin_out_tready) begin
            cmdin_out_tvalid <= 1'b0;
            if (!cmdin_out_tlast) k <= k + 8'd1;
          end
        end
        S_RWAIT: begin
          cmdin_out_tdata  <= cmdin_queue_dout;
          cmdin_out_tlast  <= (k == n_args);
          cmdin_out_tvalid <= 1'b1;
        end
        S_CLEAR: begin
          rd_ptr[acc] <= cur_ptr + SLOT_W'(n_args) + SLOT_W'(1);
          acc         <= acc + ACC_W'(1);
`ifdef CMDIN_DISPATCH_STATS_EN
          if (!bad_hdr) dispatch_count <= dispatch_count + 32'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmdin_queue_dispatcher.sv
`timescale 1ns/1ps
module tb_cmdin_queue_dispatcher;

  logic        aclk   = 1'b0;
  logic        rst_n  = 1'b0;
  logic        en;
  logic [7:0]  we;
  logic [31:0] addr;
  logic [63:0] din;
  logic [63:0] dout   = '0;
  logic        tvalid;
  logic        tready = 1'b1;
  logic [3:0]  tdest;
  logic [63:0] tdata;
  logic        tlast;
  logic        err;
`ifdef CMDIN_DISPATCH_STATS_EN
  logic [31:0] dcount;
`endif

  int checks = 0;
  int errors = 0;

  // BRAM model: 16 subqueues x 64 words, read-first, 1-cycle latency
  logic [63:0] mem [1024] = '{default: '0};
  logic        bd_we   = 1'b0;
  logic [9:0]  bd_idx  = '0;
  logic [63:0] bd_data = '0;
  logic [31:0] rd_log [$];

  always #5 aclk = ~aclk;

  cmdin_queue_dispatcher dut (
    .aclk               (aclk),
    .peripheral_aresetn (rst_n),
    .cmdin_queue_en     (en),
    .cmdin_queue_we     (we),
    .cmdin_queue_addr   (addr),
    .cmdin_queue_din    (din),
    .cmdin_queue_dout   (dout),
    .cmdin_out_tvalid   (tvalid),
    .cmdin_out_tready   (tready),
    .cmdin_out_tdest    (tdest),
    .cmdin_out_tdata    (tdata),
    .cmdin_out_tlast    (tlast),
`ifdef CMDIN_DISPATCH_STATS_EN
    .dispatch_count     (dcount),
`endif
    .dispatch_err       (err)
  );

  always @(posedge aclk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (en) begin
      for (int b = 0; b < 8; b++)
        if (we[b]) mem[addr[12:3]][b*8 +: 8] <= din[b*8 +: 8];
      dout <= mem[addr[12:3]];
    end
  end

  // Reads of subqueue 0 only
  always @(negedge aclk)
    if (en && we == 8'h00 && addr < 32'h200) rd_log.push_back(addr);

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [63:0] d);
    bd_idx  = idx[9:0];
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge aclk);
    #1 bd_we = 1'b0;
  endtask

  task automatic get_beat(output logic [63:0] d, output logic [3:0] dst,
                          output logic lst, output logic ok);
    ok = 1'b0; d = '0; dst = '0; lst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tvalid && tready) begin
        d = tdata; dst = tdest; lst = tlast; ok = 1'b1;
        @(posedge aclk);
        #1;
        break;
      end
      @(negedge aclk);
    end
  endtask

  task automatic wait_clear(output logic [31:0] a, output logic [7:0] w,
                            output logic [63:0] dd, output logic saw_tv, output logic ok);
    ok = 1'b0; a = '0; w = '0; dd = '0; saw_tv = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (tvalid) saw_tv = 1'b1;
      if (we != 8'h00) begin
        a = addr; w = we; dd = din; ok = 1'b1;
        @(posedge aclk);
        #1;
        break;
      end
    end
  endtask

  task automatic wait_scan(input logic [3:0] acc, output logic [31:0] a, output logic ok);
    ok = 1'b0; a = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (en && we == 8'h00 && addr[12:9] == acc) begin
        a = addr; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tvalid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (tvalid) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    logic [63:0] d, dd, exp;
    logic [3:0]  dst;
    logic        lst, ok, saw;
    logic [31:0] a;
    logic [7:0]  w;
    logic [63:0] ew [3];
    logic [3:0]  edst [3];
    int          n, bad;

    // ---- reset state ----
    repeat (3) @(negedge aclk);
    chk("rst_en",     64'(en),     64'd0);
    chk("rst_we",     64'(we),     64'd0);
    chk("rst_addr",   64'(addr),   64'd0);
    chk("rst_din",    din,         64'd0);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast",  64'(tlast),  64'd0);
    chk("rst_tdata",  tdata,       64'd0);
    chk("rst_tdest",  64'(tdest),  64'd0);
    chk("rst_err",    64'(err),    64'd0);

    // ---- 1: empty queues, scan order ----
    @(negedge aclk);
    rst_n = 1'b1;
    #1;
    n = 0; saw = 1'b0;
    for (int i = 0; i < 60 && n < 17; i++) begin
      if (tvalid) saw = 1'b1;
      if (en) begin
        chk($sformatf("t1_scan%0d", n), 64'(addr), 64'((n % 16) * 32'h200));
        n++;
      end
      @(negedge aclk);
    end
    chk("t1_nscan", 64'(n), 64'd17);
    chk("t1_no_tvalid", 64'(saw), 64'd0);

    // ---- 2: acc 3, N=2 ----
    poke(193, 64'hAAAA_0000_0000_000A);
    poke(194, 64'hBBBB_0000_0000_000B);
    poke(192, 64'h8000_0000_0000_0201);
    ew[0] = 64'h8000_0000_0000_0201; ew[1] = 64'hAAAA_0000_0000_000A; ew[2] = 64'hBBBB_0000_0000_000B;
    for (int i = 0; i < 3; i++) begin
      get_beat(d, dst, lst, ok);
      chk($sformatf("t2_beat%0d_ok", i),   64'(ok),  64'd1);
      chk($sformatf("t2_beat%0d_data", i), d,        ew[i]);
      chk($sformatf("t2_beat%0d_dest", i), 64'(dst), 64'd3);
      chk($sformatf("t2_beat%0d_last", i), 64'(lst), 64'(i == 2));
    end
    wait_clear(a, w, dd, saw, ok);
    chk("t2_clr_ok",   64'(ok), 64'd1);
    chk("t2_clr_addr", 64'(a),  64'h600);
    chk("t2_clr_we",   64'(w),  64'h80);
    chk("t2_clr_din",  dd,      64'd0);
    chk("t2_hdr_mem",  mem[192], 64'h0000_0000_0000_0201);
    wait_scan(4'd3, a, ok);
    chk("t2_next_scan", 64'(a), 64'h618);

    // ---- 3: backpressure on beat 2 ----
    poke(196, 64'h0000_1111_2222_3333);
    poke(197, 64'h0000_4444_5555_6666);
    poke(195, 64'h8000_0000_0000_0201);
    get_beat(d, dst, lst, ok);
    chk("t3_hdr", d, 64'h8000_0000_0000_0201);
    tready = 1'b0;
    wait_tvalid(ok);
    chk("t3_tvalid_ok", 64'(ok), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3_hold%0d_ctl", i),  64'({tvalid, tlast, tdest}), 64'({1'b1, 1'b0, 4'd3}));
      chk($sformatf("t3_hold%0d_data", i), tdata, 64'h0000_1111_2222_3333);
      @(negedge aclk);
    end
    tready = 1'b1;
    get_beat(d, dst, lst, ok);
    chk("t3_beat1", {d[63:5], lst, dst}, {64'h0000_1111_2222_3333 >> 5, 1'b0, 4'd3});
    get_beat(d, dst, lst, ok);
    chk("t3_beat2", {d[63:5], lst, dst}, {64'h0000_4444_5555_6666 >> 5, 1'b1, 4'd3});
    wait_clear(a, w, dd, saw, ok);
    chk("t3_clr_addr", 64'(a), 64'h618);

    // ---- 4: pointer wrap on acc 0 ----
    for (int i = 1; i <= 61; i++) poke(i, 64'h1000 + 64'(i));
    poke(0, 64'h8000_0000_0000_3D01);
    bad = 0;
    for (int i = 0; i < 62; i++) begin
      get_beat(d, dst, lst, ok);
      exp = (i == 0) ? 64'h8000_0000_0000_3D01 : 64'h1000 + 64'(i);
      if (!ok || d !== exp || dst !== 4'd0 || lst !== (i == 61)) bad++;
    end
    chk("t4_long_cmd_bad_beats", 64'(bad), 64'd0);
    wait_clear(a, w, dd, saw, ok);
    chk("t4_long_clr_addr", 64'(a), 64'h000);
    poke(63, 64'h0000_0000_0000_C0DE);
    poke(0,  64'h0000_0000_0000_BEEF);
    poke(62, 64'h8000_0000_0000_0201);
    get_beat(d, dst, lst, ok);
    chk("t4_hdr", d, 64'h8000_0000_0000_0201);
    rd_log.delete();
    get_beat(d, dst, lst, ok);
    chk("t4_w1", d, 64'h0000_0000_0000_C0DE);
    get_beat(d, dst, lst, ok);
    chk("t4_w2", {d[62:0], lst}, {63'h0000_0000_0000_BEEF, 1'b1});
    wait_clear(a, w, dd, saw, ok);
    chk("t4_clr_addr", 64'(a), 64'h1F0);
    for (int i = 0; i < 100 && rd_log.size() < 3; i++) @(negedge aclk);
    chk("t4_log_size", 64'(rd_log.size() >= 3), 64'd1);
    chk("t4_rd_slot63", 64'(rd_log[0]), 64'h1F8);
    chk("t4_rd_slot0",  64'(rd_log[1]), 64'h000);
    chk("t4_next_scan", 64'(rd_log[2]), 64'h008);

    // ---- 5: fairness, acc 1 refilled ----
    tready = 1'b0;
    poke(64, 64'h8000_0000_0000_0011);
    wait_tvalid(ok);
    chk("t5_first_dest", 64'(tdest), 64'd1);
    poke(128, 64'h8000_0000_0000_0022);
    poke(65,  64'h8000_0000_0000_0033);
    tready = 1'b1;
    ew[0] = 64'h8000_0000_0000_0011; ew[1] = 64'h8000_0000_0000_0022; ew[2] = 64'h8000_0000_0000_0033;
    edst[0] = 4'd1; edst[1] = 4'd2; edst[2] = 4'd1;
    for (int i = 0; i < 3; i++) begin
      get_beat(d, dst, lst, ok);
      chk($sformatf("t5_cmd%0d_data", i), d,        ew[i]);
      chk($sformatf("t5_cmd%0d_dest", i), 64'(dst), 64'(edst[i]));
      chk($sformatf("t5_cmd%0d_last", i), 64'(lst), 64'd1);
    end
    wait_clear(a, w, dd, saw, ok);
    chk("t5_clr_addr", 64'(a), 64'h208);

    // ---- 6: malformed header, async reset mid-beat ----
    poke(320, 64'h8000_0000_0000_4000);
    wait_clear(a, w, dd, saw, ok);
    chk("t6_clr_ok",    64'(ok),  64'd1);
    chk("t6_clr_addr",  64'(a),   64'hA00);
    chk("t6_clr_we",    64'(w),   64'h80);
    chk("t6_no_beats",  64'(saw), 64'd0);
    chk("t6_err",       64'(err), 64'd1);
    chk("t6_hdr_mem",   mem[320], 64'h0000_0000_0000_4000);
    wait_scan(4'd5, a, ok);
    chk("t6_next_scan", 64'(a), 64'hA08);
`ifdef CMDIN_DISPATCH_STATS_EN
    chk("t6_dispatch_count", 64'(dcount), 64'd7);
`endif
    tready = 1'b0;
    poke(449, 64'h0000_0000_0000_ABCD);
    poke(448, 64'h8000_0000_0000_0177);
    wait_tvalid(ok);
    chk("t6_stall_dest", 64'(tdest), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_tvalid", 64'(tvalid), 64'd0);
    chk("t6_async_en",     64'(en),     64'd0);
    chk("t6_hdr_kept",     mem[448],    64'h8000_0000_0000_0177);
    repeat (2) @(negedge aclk);
    chk("t6_rst_err",   64'(err), 64'd0);
    chk("t6_rst_tdata", tdata,    64'd0);
    rst_n  = 1'b1;
    tready = 1'b1;
    get_beat(d, dst, lst, ok);
    chk("t6_resend_hdr",  {d[62:0], dst}, {63'h0000_0000_0000_0177, 4'd7});
    get_beat(d, dst, lst, ok);
    chk("t6_resend_arg",  {d[62:0], lst}, {63'h0000_0000_0000_ABCD, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
